// File: rtl/dram_ctrl_pkg.sv
// Shared types and constants for the data-side DRAM AXI4 port controller.
package dram_ctrl_pkg;

    localparam int ID_W_DEF   = 4;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 16;
    localparam int LEN_W_DEF  = 7;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_2B    = 3'b001;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4,
        ST_B    = 3'd5
    } state_e;

    // Any response other than OKAY counts as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/dram_wr_seq.sv
// Write-side datapath: latches the store address/data on acceptance,
// decodes the AW/W/B channel handshakes from the controller state, and
// produces the one-cycle store-done pulse after the B handshake.
import dram_ctrl_pkg::*;

module dram_wr_seq #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  state_e            state_q,
    input  logic              wr_accept,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [DATA_W-1:0] wr_req_data,
    input  logic              bvalid_i,
    output logic [ADDR_W-1:0] awaddr_o,
    output logic              awvalid_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              wvalid_o,
    output logic              wlast_o,
    output logic              bready_o,
    output logic              wr_done
);

    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_done_q, wr_done_d;

    // The store word is 16-bit aligned, so the byte-select bit is discarded.
    logic unused_wr_lsb;
    assign unused_wr_lsb = wr_req_addr[0];

    // Capture the store on acceptance; report completion one cycle after B.
    always_comb begin
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_done_d = 1'b0;
        if (wr_accept) begin
            wr_addr_d = {wr_req_addr[ADDR_W-1:1], 1'b0};
            wr_data_d = wr_req_data;
        end
        if (state_q == ST_B && bvalid_i) begin
            wr_done_d = 1'b1;
        end
    end

    // Write-side registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_done_q <= 1'b0;
        end else begin
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_done_q <= wr_done_d;
        end
    end

    // Channel valids/readies are pure decodes of the registered state.
    assign awvalid_o = (state_q == ST_AW);
    assign wvalid_o  = (state_q == ST_W);
    assign wlast_o   = (state_q == ST_W);
    assign bready_o  = (state_q == ST_B);
    assign awaddr_o  = wr_addr_q;
    assign wdata_o   = wr_data_q;
    assign wr_done   = wr_done_q;

endmodule

// File: rtl/dram_data_port_ctrl.sv
// Data-side DRAM AXI4 port sequencer: arbitrates a cache-fill burst read
// against a single-word store (store has strict priority) and runs one
// transaction at a time over AR/R or AW/W/B.
// Optional build macro: DRAM_RESP_CHECK_EN adds the sticky resp_err output.
//
//  state | meaning
//  IDLE  | no transaction; accepts a store, else a fill
//  AR    | read address presented, waiting for arready_i
//  R     | accepting read beats until rlast_i
//  AW    | write address presented, waiting for awready_i
//  W     | single write beat presented, waiting for wready_i
//  B     | waiting for the write response
import dram_ctrl_pkg::*;

module dram_data_port_ctrl #(
    parameter int ID_W   = ID_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    input  logic [LEN_W-1:0]  rd_req_len,
    output logic              rd_data_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_last,
    input  logic              wr_req_valid,
    output logic              wr_req_ready,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [DATA_W-1:0] wr_req_data,
    output logic              wr_done,
    output logic              busy,
`ifdef DRAM_RESP_CHECK_EN
    output logic              resp_err,
`endif
    output logic [ID_W-1:0]   arid_o,
    output logic [2:0]        arsize_o,
    output logic [1:0]        arburst_o,
    output logic [ADDR_W-1:0] araddr_o,
    output logic [LEN_W-1:0]  arlen_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic              rlast_i,
    input  logic              rvalid_i,
    input  logic [1:0]        rresp_i,
    output logic              rready_o,
    output logic [ID_W-1:0]   awid_o,
    output logic [2:0]        awsize_o,
    output logic [1:0]        awburst_o,
    output logic [ADDR_W-1:0] awaddr_o,
    output logic [LEN_W-1:0]  awlen_o,
    output logic              awvalid_o,
    input  logic              awready_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic              wlast_o,
    output logic              wvalid_o,
    input  logic              wready_i,
    input  logic              bvalid_i,
    input  logic [1:0]        bresp_i,
    output logic              bready_o
);

    state_e state_q, state_d;

    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [LEN_W-1:0]  rd_len_q, rd_len_d;
    logic [LEN_W:0]    beat_cnt_q, beat_cnt_d;
    logic              rd_data_valid_q, rd_data_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_data_last_q, rd_data_last_d;

    logic r_beat;

    // Fill bursts are 16-bit aligned, so the byte-select bit is discarded.
    logic unused_rd_lsb;
    assign unused_rd_lsb = rd_req_addr[0];

    assign r_beat = (state_q == ST_R) && rvalid_i;

    // Next-state and request acceptance; stores win over fills in IDLE.
    always_comb begin
        state_d      = state_q;
        rd_req_ready = 1'b0;
        wr_req_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_req_valid) begin
                    wr_req_ready = 1'b1;
                    state_d      = ST_AW;
                end else if (rd_req_valid) begin
                    rd_req_ready = 1'b1;
                    state_d      = ST_AR;
                end
            end
            ST_AR: if (arready_i) state_d = ST_R;
            ST_R:  if (rvalid_i && rlast_i) state_d = ST_IDLE;
            ST_AW: if (awready_i) state_d = ST_W;
            ST_W:  if (wready_i) state_d = ST_B;
            ST_B:  if (bvalid_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read-side datapath: latch the fill request, count beats, and return
    // each accepted beat one cycle later. rlast_i alone ends the burst; the
    // beat count is kept for observability and does not gate termination.
    always_comb begin
        rd_addr_d       = rd_addr_q;
        rd_len_d        = rd_len_q;
        beat_cnt_d      = beat_cnt_q;
        rd_data_d       = rd_data_q;
        rd_data_valid_d = 1'b0;
        rd_data_last_d  = 1'b0;
        if (rd_req_ready) begin
            rd_addr_d  = {rd_req_addr[ADDR_W-1:1], 1'b0};
            rd_len_d   = rd_req_len;
            beat_cnt_d = '0;
        end
        if (r_beat) begin
            beat_cnt_d      = beat_cnt_q + 1'b1;
            rd_data_d       = rdata_i;
            rd_data_valid_d = 1'b1;
            rd_data_last_d  = rlast_i;
        end
    end

    // Read-side registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr_q       <= '0;
            rd_len_q        <= '0;
            beat_cnt_q      <= '0;
            rd_data_q       <= '0;
            rd_data_valid_q <= 1'b0;
            rd_data_last_q  <= 1'b0;
        end else begin
            rd_addr_q       <= rd_addr_d;
            rd_len_q        <= rd_len_d;
            beat_cnt_q      <= beat_cnt_d;
            rd_data_q       <= rd_data_d;
            rd_data_valid_q <= rd_data_valid_d;
            rd_data_last_q  <= rd_data_last_d;
        end
    end

`ifdef DRAM_RESP_CHECK_EN
    logic resp_err_q, resp_err_d;

    // Sticky error flag on any non-OKAY read beat or write response.
    always_comb begin
        resp_err_d = resp_err_q;
        if (r_beat && resp_is_err(rresp_i)) begin
            resp_err_d = 1'b1;
        end
        if (state_q == ST_B && bvalid_i && resp_is_err(bresp_i)) begin
            resp_err_d = 1'b1;
        end
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_err_q <= 1'b0;
        end else begin
            resp_err_q <= resp_err_d;
        end
    end

    assign resp_err = resp_err_q;
`else
    logic unused_resp;
    assign unused_resp = ^{rresp_i, bresp_i};
`endif

    dram_wr_seq #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wr_seq (
        .clk         (clk),
        .rst         (rst),
        .state_q     (state_q),
        .wr_accept   (wr_req_ready),
        .wr_req_addr (wr_req_addr),
        .wr_req_data (wr_req_data),
        .bvalid_i    (bvalid_i),
        .awaddr_o    (awaddr_o),
        .awvalid_o   (awvalid_o),
        .wdata_o     (wdata_o),
        .wvalid_o    (wvalid_o),
        .wlast_o     (wlast_o),
        .bready_o    (bready_o),
        .wr_done     (wr_done)
    );

    assign busy          = (state_q != ST_IDLE);
    assign arvalid_o     = (state_q == ST_AR);
    assign rready_o      = (state_q == ST_R);
    assign araddr_o      = rd_addr_q;
    assign arlen_o       = rd_len_q;
    assign rd_data_valid = rd_data_valid_q;
    assign rd_data       = rd_data_q;
    assign rd_data_last  = rd_data_last_q;

    assign arid_o    = '0;
    assign awid_o    = '0;
    assign arsize_o  = AXI_SIZE_2B;
    assign awsize_o  = AXI_SIZE_2B;
    assign arburst_o = AXI_BURST_INCR;
    assign awburst_o = AXI_BURST_INCR;
    assign awlen_o   = '0;

endmodule

// File: tb/tb_dram_data_port_ctrl.sv
// Directed bench for dram_data_port_ctrl; the bench plays the DRAM slave.
// Returned read words are scoreboarded against what the slave drove.
module tb_dram_data_port_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_req_valid = 1'b0;
    logic        rd_req_ready;
    logic [31:0] rd_req_addr = '0;
    logic [6:0]  rd_req_len = '0;
    logic        rd_data_valid;
    logic [15:0] rd_data;
    logic        rd_data_last;
    logic        wr_req_valid = 1'b0;
    logic        wr_req_ready;
    logic [31:0] wr_req_addr = '0;
    logic [15:0] wr_req_data = '0;
    logic        wr_done;
    logic        busy;
`ifdef DRAM_RESP_CHECK_EN
    logic        resp_err;
`endif
    logic [3:0]  arid_o, awid_o;
    logic [2:0]  arsize_o, awsize_o;
    logic [1:0]  arburst_o, awburst_o;
    logic [31:0] araddr_o, awaddr_o;
    logic [6:0]  arlen_o, awlen_o;
    logic        arvalid_o, rready_o, awvalid_o, wlast_o, wvalid_o, bready_o;
    logic [15:0] wdata_o;
    logic        arready_i = 1'b0;
    logic [15:0] rdata_i = '0;
    logic        rlast_i = 1'b0;
    logic        rvalid_i = 1'b0;
    logic [1:0]  rresp_i = '0;
    logic        awready_i = 1'b0;
    logic        wready_i = 1'b0;
    logic        bvalid_i = 1'b0;
    logic [1:0]  bresp_i = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_done_cnt = 0;
    logic [16:0] sb[$];

    always #5 clk = ~clk;

    dram_data_port_ctrl dut (
        .clk(clk), .rst(rst),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rd_data_last(rd_data_last),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
        .wr_done(wr_done), .busy(busy),
`ifdef DRAM_RESP_CHECK_EN
        .resp_err(resp_err),
`endif
        .arid_o(arid_o), .arsize_o(arsize_o), .arburst_o(arburst_o),
        .araddr_o(araddr_o), .arlen_o(arlen_o), .arvalid_o(arvalid_o),
        .arready_i(arready_i),
        .rdata_i(rdata_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i), .rresp_i(rresp_i),
        .rready_o(rready_o),
        .awid_o(awid_o), .awsize_o(awsize_o), .awburst_o(awburst_o),
        .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awvalid_o(awvalid_o),
        .awready_i(awready_i),
        .wdata_o(wdata_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o),
        .wready_i(wready_i),
        .bvalid_i(bvalid_i), .bresp_i(bresp_i), .bready_o(bready_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Returned-word monitor: pops the scoreboard on every rd_data_valid.
    always @(negedge clk) begin
        if (rd_data_valid === 1'b1) begin
            chk("rd_sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                chk("rd_beat_last_data", 32'({rd_data_last, rd_data}), 32'(sb.pop_front()));
            end
        end
        if (wr_done === 1'b1) wr_done_cnt++;
    end

    task automatic wait_sig(input string tag, input int which);
        int n = 0;
        logic s;
        s = (which == 0) ? arvalid_o : awvalid_o;
        while (s !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
            s = (which == 0) ? arvalid_o : awvalid_o;
        end
        chk(tag, 32'(s), 32'd1);
    endtask

    task automatic issue_rd(input logic [31:0] addr, input logic [6:0] len);
        rd_req_valid = 1'b1; rd_req_addr = addr; rd_req_len = len;
        #1;
        chk("rd_req_ready", 32'(rd_req_ready), 32'd1);
        @(negedge clk);
        rd_req_valid = 1'b0;
        chk("busy_after_rd_req", 32'(busy), 32'd1);
    endtask

    task automatic issue_wr(input logic [31:0] addr, input logic [15:0] data);
        wr_req_valid = 1'b1; wr_req_addr = addr; wr_req_data = data;
        #1;
        chk("wr_req_ready", 32'(wr_req_ready), 32'd1);
        @(negedge clk);
        wr_req_valid = 1'b0;
        chk("busy_after_wr_req", 32'(busy), 32'd1);
    endtask

    // DRAM read slave; stop_at >= 0 abandons the burst before that beat.
    task automatic rd_slave(input logic [31:0] exp_addr, input logic [6:0] exp_len,
                            input int ar_delay, input int nbeats, input int stop_at);
        wait_sig("arvalid_wait", 0);
        chk("araddr", araddr_o, exp_addr);
        chk("arlen", 32'(arlen_o), 32'(exp_len));
        for (int i = 0; i < ar_delay; i++) begin
            @(negedge clk);
            chk("arvalid_held", 32'(arvalid_o), 32'd1);
            chk("araddr_stable", araddr_o, exp_addr);
            chk("arlen_stable", 32'(arlen_o), 32'(exp_len));
        end
        arready_i = 1'b1;
        @(negedge clk);
        arready_i = 1'b0;
        chk("arvalid_dropped", 32'(arvalid_o), 32'd0);
        chk("rready", 32'(rready_o), 32'd1);
        for (int i = 0; i < nbeats; i++) begin
            if (i == stop_at) begin
                rvalid_i = 1'b0;
                rlast_i  = 1'b0;
                return;
            end
            if (i % 9 == 4) begin
                rvalid_i = 1'b0;
                rlast_i  = 1'b0;
                @(negedge clk);
            end
            rdata_i  = 16'($urandom_range(0, 65535));
            rlast_i  = (i == nbeats - 1);
            rvalid_i = 1'b1;
            sb.push_back({rlast_i, rdata_i});
            @(negedge clk);
        end
        rvalid_i = 1'b0;
        rlast_i  = 1'b0;
        chk("busy_after_fill", 32'(busy), 32'd0);
        chk("last_word_in_idle", 32'(rd_data_last), 32'd1);
        @(negedge clk);
        chk("rd_data_valid_quiet", 32'(rd_data_valid), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    // DRAM write slave with independent AW and W ready delays.
    task automatic wr_slave(input logic [31:0] exp_addr, input logic [15:0] exp_data,
                            input int aw_delay, input int w_delay, input logic [1:0] resp);
        int done_before;
        done_before = wr_done_cnt;
        wait_sig("awvalid_wait", 1);
        chk("awaddr", awaddr_o, exp_addr);
        chk("awlen", 32'(awlen_o), 32'd0);
        chk("w_not_before_aw", 32'(wvalid_o), 32'd0);
        chk("no_ar_during_wr", 32'(arvalid_o), 32'd0);
        for (int i = 0; i < aw_delay; i++) begin
            @(negedge clk);
            chk("awvalid_held", 32'(awvalid_o), 32'd1);
            chk("awaddr_stable", awaddr_o, exp_addr);
            chk("w_not_before_aw", 32'(wvalid_o), 32'd0);
        end
        awready_i = 1'b1;
        @(negedge clk);
        awready_i = 1'b0;
        chk("awvalid_dropped", 32'(awvalid_o), 32'd0);
        chk("wvalid", 32'(wvalid_o), 32'd1);
        chk("wlast", 32'(wlast_o), 32'd1);
        chk("wdata", 32'(wdata_o), 32'(exp_data));
        for (int i = 0; i < w_delay; i++) begin
            @(negedge clk);
            chk("wvalid_held", 32'(wvalid_o), 32'd1);
            chk("wdata_stable", 32'(wdata_o), 32'(exp_data));
        end
        wready_i = 1'b1;
        @(negedge clk);
        wready_i = 1'b0;
        chk("wvalid_dropped", 32'(wvalid_o), 32'd0);
        chk("bready", 32'(bready_o), 32'd1);
        chk("wr_done_early", 32'(wr_done), 32'd0);
        bvalid_i = 1'b1;
        bresp_i  = resp;
        @(negedge clk);
        bvalid_i = 1'b0;
        bresp_i  = 2'b00;
        chk("wr_done_pulse", 32'(wr_done), 32'd1);
        chk("busy_after_store", 32'(busy), 32'd0);
        chk("no_ar_before_done", 32'(arvalid_o), 32'd0);
        @(negedge clk);
        chk("wr_done_single", 32'(wr_done), 32'd0);
        chk("wr_done_count", 32'(wr_done_cnt - done_before), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_arvalid", 32'(arvalid_o), 32'd0);
        chk("rst_awvalid", 32'(awvalid_o), 32'd0);
        chk("rst_wvalid", 32'(wvalid_o), 32'd0);
        chk("rst_rready", 32'(rready_o), 32'd0);
        chk("rst_bready", 32'(bready_o), 32'd0);
        chk("rst_rd_data_valid", 32'(rd_data_valid), 32'd0);
        chk("rst_wr_done", 32'(wr_done), 32'd0);
        chk("rst_araddr", araddr_o, 32'd0);
        chk("rst_awaddr", awaddr_o, 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("arsize", 32'(arsize_o), 32'd1);
        chk("awsize", 32'(awsize_o), 32'd1);
        chk("arburst", 32'(arburst_o), 32'd1);
        chk("awburst", 32'(awburst_o), 32'd1);
        chk("arid", 32'(arid_o), 32'd0);
        chk("awid", 32'(awid_o), 32'd0);
`ifdef DRAM_RESP_CHECK_EN
        chk("rst_resp_err", 32'(resp_err), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Full 128-beat fill.
        issue_rd(32'h0000_1000, 7'd127);
        rd_slave(32'h0000_1000, 7'd127, 0, 128, -1);

        // Single store.
        issue_wr(32'h0000_1002, 16'hBEEF);
        wr_slave(32'h0000_1002, 16'hBEEF, 0, 0, 2'b00);

        // Store and fill requested together: store goes first.
        wr_req_valid = 1'b1; wr_req_addr = 32'h0000_3000; wr_req_data = 16'h1234;
        rd_req_valid = 1'b1; rd_req_addr = 32'h0000_4000; rd_req_len = 7'd7;
        #1;
        chk("both_wr_ready", 32'(wr_req_ready), 32'd1);
        chk("both_rd_ready", 32'(rd_req_ready), 32'd0);
        @(negedge clk);
        wr_req_valid = 1'b0;
        wr_slave(32'h0000_3000, 16'h1234, 0, 0, 2'b00);
        rd_req_valid = 1'b0;
        rd_slave(32'h0000_4000, 7'd7, 0, 8, -1);

        // Slow handshakes.
        issue_wr(32'h0000_5004, 16'hA5A5);
        wr_slave(32'h0000_5004, 16'hA5A5, 3, 2, 2'b00);
        issue_rd(32'h0000_6000, 7'd3);
        rd_slave(32'h0000_6000, 7'd3, 5, 4, -1);

        // Odd address fill, reset at beat 40 of 64.
        issue_rd(32'h0000_2003, 7'd63);
        rd_slave(32'h0000_2002, 7'd63, 0, 64, 40);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rready", 32'(rready_o), 32'd0);
        chk("midrst_rd_data_valid", 32'(rd_data_valid), 32'd0);
        chk("midrst_rd_data", 32'(rd_data), 32'd0);
        chk("midrst_araddr", araddr_o, 32'd0);
        chk("midrst_arvalid", 32'(arvalid_o), 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue_rd(32'h0000_7001, 7'd15);
        rd_slave(32'h0000_7000, 7'd15, 1, 16, -1);

`ifdef DRAM_RESP_CHECK_EN
        chk("resp_err_clean", 32'(resp_err), 32'd0);
        issue_wr(32'h0000_8000, 16'h0F0F);
        wr_slave(32'h0000_8000, 16'h0F0F, 0, 0, 2'b10);
        chk("resp_err_set", 32'(resp_err), 32'd1);
        issue_rd(32'h0000_9000, 7'd2);
        rd_slave(32'h0000_9000, 7'd2, 0, 3, -1);
        chk("resp_err_sticky", 32'(resp_err), 32'd1);
        chk("wr_done_total", 32'(wr_done_cnt), 32'd4);
`else
        chk("wr_done_total", 32'(wr_done_cnt), 32'd3);
`endif
        chk("sb_final_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dram_data_port_ctrl.md
Name: dram_data_port_ctrl

Overview:
Sequences the data-side DRAM AXI4 port: one burst-read channel and the single write channel. Arbitrates between a cache-fill read requester and a single-word store requester, and drives the AR/R and AW/W/B handshakes. Sits between the core's data cache / load-store unit and the DRAM AXI slave. Its busy output feeds the core stall / IO_stall logic.

Parameters:
ID_W, 4, AXI ID width
ADDR_W, 32, AXI address width (byte address)
DATA_W, 16, AXI data width (one word per beat)
LEN_W, 7, AXI burst length field width (beats-1)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous reset, active-high
rd_req_valid  in  1  fill request valid
rd_req_ready  out  1  fill request accepted this cycle
rd_req_addr  in  ADDR_W  fill start byte address
rd_req_len  in  LEN_W  beats-1 (0..127)
rd_data_valid  out  1  one returned word this cycle
rd_data  out  DATA_W  returned word
rd_data_last  out  1  final word of fill
wr_req_valid  in  1  store request valid
wr_req_ready  out  1  store accepted this cycle
wr_req_addr  in  ADDR_W  store byte address
wr_req_data  in  DATA_W  store word
wr_done  out  1  one-cycle pulse, store acknowledged by DRAM
busy  out  1  state != IDLE
arid_o/awid_o  out  ID_W each  constant 0
arsize_o/awsize_o  out  3 each  constant 3'b001
arburst_o/awburst_o  out  2 each  constant 2'b01 (INCR)
araddr_o, arlen_o, arvalid_o  out  ADDR_W,LEN_W,1  read address channel
arready_i  in  1
rdata_i, rlast_i, rvalid_i, rresp_i  in  DATA_W,1,1,2  read data channel
rready_o  out  1
awaddr_o, awlen_o, awvalid_o  out  ADDR_W,LEN_W,1  write address channel; awlen_o constant 0
awready_i  in  1
wdata_o, wlast_o, wvalid_o  out  DATA_W,1,1  write data channel
wready_i  in  1
bvalid_i, bresp_i  in  1,2  write response
bready_o  out  1

Behaviour:
- FSM states: IDLE, AR, R, AW, W, B.
- Reset: state=IDLE; every output valid, ready and pulse = 0; address/len/data registers = 0.
- Reset mid-transaction: abandon immediately, return to IDLE; the DRAM model is reset alongside.
- IDLE: if wr_req_valid -> wr_req_ready=1, latch addr/data, go AW. Else if rd_req_valid -> rd_req_ready=1, latch addr/len, go AR.
- Both valid in IDLE: write wins (strict priority, preserves store-before-refill order); read stays pending.
- Address bit 0 forced to 0 on latch (16-bit alignment).
- Requester guarantees the burst does not cross a 4 KB boundary; not checked.
- AR: arvalid_o=1, araddr_o/arlen_o stable until arready_i; on handshake go R.
- R: rready_o=1. Each rvalid_i beat registers rd_data=rdata_i and rd_data_valid=1 next cycle (1-cycle latency, no backpressure); rd_data_last=rlast_i.
- R exit: on the rlast_i beat go IDLE; the last rd_data_valid appears in the IDLE cycle.
- Beat counter: counts accepted beats. If rlast_i arrives at a count != arlen+1, rlast_i still ends the burst.
- AW: awvalid_o=1, stable until awready_i, then go W. W is never issued before AW.
- W: wvalid_o=1, wlast_o=1, wdata_o=latched data; on wready_i go B.
- B: bready_o=1; on bvalid_i, wr_done pulses the next cycle and state goes IDLE.
- No new request is accepted before returning to IDLE (one outstanding transaction).
- Ready and valid signals come from the current state (registered); no combinational path from *_i to *_valid_o.

Optional Feature:
DRAM_RESP_CHECK_EN.
- Defined: adds output resp_err (1 bit, reset 0), set sticky when rresp_i != 0 on any accepted R beat or bresp_i != 0 on the B handshake; cleared only by rst.
- Undefined: port and logic absent; rresp_i and bresp_i are ignored.

Decomposition:
- Package dram_ctrl_pkg: state enum; AXI_BURST_INCR=2'b01; AXI_SIZE_2B=3'b001; AXI_RESP_OKAY=2'b00; default widths.
- No sub-module required. Optionally split the write sequencer (AW/W/B) into dram_wr_seq.

Test Plan:
- Fill: rd_req addr 0x1000 len 127 -> araddr 0x1000, arlen 127; 128 rd_data_valid pulses matching rdata; rd_data_last only on beat 128; busy falls after.
- Store: wr_req addr 0x1002 data 0xBEEF -> awaddr 0x1002, awlen 0; wdata 0xBEEF with wlast=1; wr_done pulses exactly once, 1 cycle after bvalid.
- Both requests valid in the same IDLE cycle -> store completes (wr_done) before arvalid_o rises; then fill proceeds.
- arready delayed 5 cycles, awready delayed 3, wready delayed 2 -> valids held, addresses and data stable, no duplicate handshakes.
- Odd address 0x2003 on read -> araddr 0x2002. rst asserted at beat 40 of a 64-beat fill -> all outputs 0 the same cycle; new fill after reset starts cleanly.
- With DRAM_RESP_CHECK_EN: bresp=2'b10 on one store -> resp_err=1 and stays 1 through later OKAY transactions.
